// File: rtl/week5_ex3_scan_sequencer_pkg.sv
// rtl/week5_ex3_scan_sequencer_pkg.sv - shared types, widths and select-advance helper for the scan sequencer
package week5_ex3_scan_sequencer_pkg;

  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  // True when the current code is the last one used, so the next advance wraps to 0.
  function automatic logic is_last_sel(input logic [SEL_W-1:0] sel, input int unsigned num_digits);
    return (32'(sel) == num_digits - 1);
  endfunction

  // Next digit code; wraps at num_digits-1 so sel never leaves the legal range.
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel, input int unsigned num_digits);
    if (is_last_sel(sel, num_digits)) begin
      return '0;
    end
    return sel + SEL_W'(1);
  endfunction

endpackage

// File: rtl/week5_ex3_scan_sequencer_if.sv
// rtl/week5_ex3_scan_sequencer_if.sv - control/select bundle between scan controller and sequencer
interface week5_ex3_scan_sequencer_if;
  import week5_ex3_scan_sequencer_pkg::*;

  logic             en;
  logic             manual;
  logic             step;
  logic [SEL_W-1:0] sel;
  logic             active;
  logic             frame_done;

  modport master (
    output en, manual, step,
    input  sel, active, frame_done
  );

  modport slave (
    input  en, manual, step,
    output sel, active, frame_done
  );

endinterface

// File: rtl/week5_ex3_scan_sequencer_tick_counter.sv
// rtl/week5_ex3_scan_sequencer_tick_counter.sv - clearable up-counter with terminal-count flag
module week5_ex3_scan_sequencer_tick_counter #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] TC_VALUE = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_count;

  // Count up while enabled; clear wins so the owner can restart a period at any time.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_tc = (r_count == TC_VALUE);

endmodule

// File: rtl/week5_ex3_scan_sequencer.sv
// rtl/week5_ex3_scan_sequencer.sv - digit-select scan sequencer with dwell, blanking and manual stepping
module week5_ex3_scan_sequencer
  import week5_ex3_scan_sequencer_pkg::*;
#(
  parameter int PRESCALE     = 4,
  parameter int BLANK_CYCLES = 1,
  parameter int NUM_DIGITS   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  week5_ex3_scan_sequencer_if.slave     io_scan
);

  localparam logic HAS_BLANK   = (BLANK_CYCLES > 0);
  // Blank counter is never entered when there is no gap; keep its limit legal anyway.
  localparam int   BLANK_LIMIT = HAS_BLANK ? BLANK_CYCLES : 1;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic             r_active;
  logic             r_frame_done;

  logic w_dwell_tc;
  logic w_blank_tc;
  logic w_dwell_inc;
  logic w_blank_inc;
  logic w_dwell_end;
  logic w_wrap;
  logic [SEL_W-1:0] w_sel_next;

  // Dwell counts only in auto SHOW; manual mode and every period end hold it at 0.
  assign w_dwell_inc = (r_state == ST_SHOW) && io_scan.en && !io_scan.manual && !w_dwell_tc;
  assign w_blank_inc = (r_state == ST_BLANK) && io_scan.en && !w_blank_tc;
  assign w_dwell_end = io_scan.manual ? io_scan.step : w_dwell_tc;
  assign w_wrap      = is_last_sel(r_sel, NUM_DIGITS);
  assign w_sel_next  = next_sel(r_sel, NUM_DIGITS);

  week5_ex3_scan_sequencer_tick_counter #(
    .WIDTH (16),
    .LIMIT (PRESCALE)
  ) u_dwell_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (!w_dwell_inc),
    .i_inc   (w_dwell_inc),
    .o_tc    (w_dwell_tc)
  );

  week5_ex3_scan_sequencer_tick_counter #(
    .WIDTH (8),
    .LIMIT (BLANK_LIMIT)
  ) u_blank_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (!w_blank_inc),
    .i_inc   (w_blank_inc),
    .o_tc    (w_blank_tc)
  );

  // Scan FSM with registered sel/active/frame_done; disable beats any pending advance.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_sel        <= '0;
      r_active     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (!io_scan.en) begin
        r_state  <= ST_IDLE;
        r_sel    <= '0;
        r_active <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state  <= ST_SHOW;
            r_sel    <= '0;
            r_active <= 1'b1;
          end
          ST_SHOW: begin
            if (w_dwell_end) begin
              if (HAS_BLANK) begin
                r_state  <= ST_BLANK;
                r_active <= 1'b0;
              end else begin
                r_sel        <= w_sel_next;
                r_frame_done <= w_wrap;
              end
            end
          end
          ST_BLANK: begin
            if (w_blank_tc) begin
              r_state      <= ST_SHOW;
              r_active     <= 1'b1;
              r_sel        <= w_sel_next;
              r_frame_done <= w_wrap;
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_scan.sel        = r_sel;
  assign io_scan.active     = r_active;
  assign io_scan.frame_done = r_frame_done;

endmodule
